mod_exp_ctrl: RTL and testbench

- Sequences one Montgomery multiplier to compute result = base^exponent mod modulus by left-to-right square-and-multiply in the Montgomery domain.
- Sits between the RSA top-level register interface and the multiplier. It owns the md_start/md_end handshake and drives the multiplier operand buses.
- Montgomery radix is R = 2^len. The caller supplies r2_mod = R^2 mod modulus.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/mm_handshake.sv | 100 ++++++++++
 rtl/mod_exp_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation controller.
//   - top_state_t : exponentiation sequencer states
//   - hs_state_t  : multiplier handshake states
//   - DEFAULT_WIDTH / DEFAULT_TIMEOUT_CYC : default parameter values
package rsa_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_B,
        ST_PRE_A,
        ST_SQR,
        ST_MUL,
        ST_POST,
        ST_FIN
    } top_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_ISSUE,
        HS_WAIT_HI,
        HS_WAIT_LO
    } hs_state_t;

endpackage

// File: rtl/mm_handshake.sv
// One Montgomery-multiplier transaction: ISSUE -> WAIT_HI -> WAIT_LO.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   go         : request a multiplication (level; sampled while idle)
//   md_end     : multiplier completion level
//   mm_out     : multiplier result, valid while md_end is high
//   md_start   : one-cycle start pulse to the multiplier
//   ack        : one-cycle pulse once md_end has fallen again
//   cap_value  : mm_out captured on the first md_end high cycle
//   timeout    : one-cycle pulse when the wait budget is exhausted
module mm_handshake
    import rsa_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             go,
    input  logic             md_end,
    input  logic [WIDTH-1:0] mm_out,
    output logic             md_start,
    output logic             ack,
    output logic [WIDTH-1:0] cap_value,
    output logic             timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // cnt_reg holds the number of cycles elapsed since md_start. Aborting
    // when it reaches TIMEOUT_CYC-1 puts the caller's FIN cycle exactly
    // TIMEOUT_CYC cycles after the md_start pulse.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    hs_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic             expired;

    assign expired   = (cnt_reg >= CNT_LAST);
    assign cap_value = cap_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= HS_IDLE;
            cnt_reg   <= '0;
            cap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cap_reg   <= cap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cap_next   = cap_reg;
        md_start   = 1'b0;
        ack        = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            HS_IDLE: begin
                // Never launch while the multiplier still reports done.
                if (go && !md_end) begin
                    state_next = HS_ISSUE;
                end
            end
            HS_ISSUE: begin
                md_start   = 1'b1;
                cnt_next   = CNT_W'(1);
                state_next = HS_WAIT_HI;
            end
            HS_WAIT_HI: begin
                if (md_end) begin
                    cap_next   = mm_out;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = HS_WAIT_LO;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = HS_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HS_WAIT_LO: begin
                if (!md_end) begin
                    ack        = 1'b1;
                    state_next = HS_IDLE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = HS_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = HS_IDLE;
        endcase
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer around one Montgomery
// multiplier: result = base^exponent mod modulus, with R = 2^len.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   start              : one-cycle request, sampled only in IDLE
//   len, base, exponent, modulus, r2_mod : operation inputs, latched at start
//   busy, done, err    : status; done pulses once with result/err valid
//   result             : final value, held until the next accepted start
//   md_start, mm_len, mm_a, mm_b, mm_mod : multiplier request side
//   md_end, mm_out     : multiplier completion side
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r2_mod,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             md_start,
    output logic [7:0]       mm_len,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_mod,
    input  logic             md_end,
    input  logic [WIDTH-1:0] mm_out
);

    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [31:0]      WIDTH_U = 32'(WIDTH);

    top_state_t       state_reg, state_next;
    logic [7:0]       idx_reg, idx_next;
    logic [7:0]       len_reg, len_next;
    logic [WIDTH-1:0] base_reg, base_next;
    logic [WIDTH-1:0] exp_reg, exp_next;
    logic [WIDTH-1:0] mod_reg, mod_next;
    logic [WIDTH-1:0] r2_reg, r2_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] base_m_reg, base_m_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             err_reg, err_next;

    logic             op_active;
    logic             len_bad;
    logic             exp_bit;
    logic             hs_ack;
    logic             hs_timeout;
    logic [WIDTH-1:0] hs_cap;

    assign op_active = (state_reg == ST_PRE_B) || (state_reg == ST_PRE_A) ||
                       (state_reg == ST_SQR)   || (state_reg == ST_MUL)   ||
                       (state_reg == ST_POST);
    assign len_bad   = (len == 8'd0) || ({24'd0, len} > WIDTH_U);
    // idx_reg never exceeds WIDTH-1 once an operation is running.
    assign exp_bit   = exp_reg[idx_reg[IDX_W-1:0]];

    assign busy   = op_active;
    assign done   = (state_reg == ST_FIN);
    assign err    = err_reg;
    assign result = result_reg;
    assign mm_len = len_reg;

    mm_handshake #(
        .WIDTH       (WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_hs (
        .clk       (clk),
        .rstn      (rstn),
        .go        (op_active),
        .md_end    (md_end),
        .mm_out    (mm_out),
        .md_start  (md_start),
        .ack       (hs_ack),
        .cap_value (hs_cap),
        .timeout   (hs_timeout)
    );

    // Operands only change when the state or acc changes, which happens on
    // ack, i.e. after md_end has fallen, so they stay stable per operation.
    always_comb begin
        mm_a   = '0;
        mm_b   = '0;
        mm_mod = '0;
        case (state_reg)
            ST_PRE_B: begin mm_a = base_reg; mm_b = r2_reg;     mm_mod = mod_reg; end
            ST_PRE_A: begin mm_a = ONE;      mm_b = r2_reg;     mm_mod = mod_reg; end
            ST_SQR:   begin mm_a = acc_reg;  mm_b = acc_reg;    mm_mod = mod_reg; end
            ST_MUL:   begin mm_a = acc_reg;  mm_b = base_m_reg; mm_mod = mod_reg; end
            ST_POST:  begin mm_a = acc_reg;  mm_b = ONE;        mm_mod = mod_reg; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            len_reg    <= '0;
            base_reg   <= '0;
            exp_reg    <= '0;
            mod_reg    <= '0;
            r2_reg     <= '0;
            acc_reg    <= '0;
            base_m_reg <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            base_reg   <= base_next;
            exp_reg    <= exp_next;
            mod_reg    <= mod_next;
            r2_reg     <= r2_next;
            acc_reg    <= acc_next;
            base_m_reg <= base_m_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        base_next   = base_reg;
        exp_next    = exp_reg;
        mod_next    = mod_reg;
        r2_next     = r2_reg;
        acc_next    = acc_reg;
        base_m_next = base_m_reg;
        result_next = result_reg;
        err_next    = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next    = len;
                    base_next   = base;
                    exp_next    = exponent;
                    mod_next    = modulus;
                    r2_next     = r2_mod;
                    idx_next    = len - 8'd1;
                    err_next    = 1'b0;
                    result_next = '0;
                    if (len_bad) begin
                        err_next   = 1'b1;
                        state_next = ST_FIN;
                    end else begin
                        state_next = ST_PRE_B;
                    end
                end
            end
            ST_PRE_B: begin
                if (hs_ack) begin
                    base_m_next = hs_cap;
                    state_next  = ST_PRE_A;
                end
            end
            ST_PRE_A: begin
                if (hs_ack) begin
                    acc_next   = hs_cap;
                    state_next = ST_SQR;
                end
            end
            ST_SQR: begin
                if (hs_ack) begin
                    acc_next = hs_cap;
                    if (exp_bit) begin
                        state_next = ST_MUL;
                    end else if (idx_reg == 8'd0) begin
                        state_next = ST_POST;
                    end else begin
                        idx_next = idx_reg - 8'd1;
                    end
                end
            end
            ST_MUL: begin
                if (hs_ack) begin
                    acc_next = hs_cap;
                    if (idx_reg == 8'd0) begin
                        state_next = ST_POST;
                    end else begin
                        idx_next   = idx_reg - 8'd1;
                        state_next = ST_SQR;
                    end
                end
            end
            ST_POST: begin
                if (hs_ack) begin
                    result_next = hs_cap;
                    state_next  = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // A stalled multiplier aborts whichever operation is in flight.
        if (op_active && hs_timeout) begin
            err_next    = 1'b1;
            result_next = '0;
            state_next  = ST_FIN;
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
`timescale 1ns/1ps
module tb_mod_exp_ctrl;

    localparam int WIDTH       = 32;
    localparam int TIMEOUT_CYC = 1024;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start = 1'b0;
    logic [7:0]       len = '0;
    logic [WIDTH-1:0] base = '0, exponent = '0, modulus = '0, r2_mod = '0;
    logic             busy, done, err, md_start;
    logic [WIDTH-1:0] result, mm_a, mm_b, mm_mod;
    logic [7:0]       mm_len;
    logic             md_end;
    logic [WIDTH-1:0] mm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mod_exp_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .base(base),
        .exponent(exponent), .modulus(modulus), .r2_mod(r2_mod),
        .busy(busy), .done(done), .err(err), .result(result),
        .md_start(md_start), .mm_len(mm_len), .mm_a(mm_a), .mm_b(mm_b),
        .mm_mod(mm_mod), .md_end(md_end), .mm_out(mm_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Montgomery product a*b*2^-l mod n via bitwise reduction.
    function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] n, input logic [7:0] l);
        logic [95:0] t;
        if (n == '0) return '0;
        t = 96'(a) * 96'(b);
        for (int k = 0; k < int'(l); k++) begin
            if (t[0]) t = t + 96'(n);
            t = t >> 1;
        end
        if (t >= 96'(n)) t = t - 96'(n);
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] n, input int l);
        logic [63:0] r, bb;
        bb = b % n;
        r  = 64'd1 % n;
        for (int k = l - 1; k >= 0; k--) begin
            r = (r * r) % n;
            if (e[k]) r = (r * bb) % n;
        end
        return r;
    endfunction

    function automatic logic [63:0] r2_of(input logic [63:0] n, input int l);
        logic [63:0] x;
        x = (64'd1 << l) % n;
        return (x * x) % n;
    endfunction

    function automatic int pulses_for(input int l, input logic [WIDTH-1:0] e);
        int p;
        p = 3 + l;
        for (int k = 0; k < l; k++) if (e[k]) p++;
        return p;
    endfunction

    // ---------------- multiplier model ----------------
    bit               mdl_silent = 1'b0;
    int               md_pulses = 0;
    longint           first_start_cyc = 0;
    int               mdl_phase, mdl_cnt, mdl_hi;
    logic [WIDTH-1:0] mdl_val, sa, sb, sm;

    initial begin
        md_end    = 1'b0;
        mm_out    = 32'hDEADBEEF;
        mdl_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                mdl_phase = 0;
                md_end    = 1'b0;
                mm_out    = 32'hDEADBEEF;
            end else begin
                case (mdl_phase)
                    0: if (md_start === 1'b1) begin
                        md_pulses++;
                        if (md_pulses == 1) first_start_cyc = cyc;
                        sa = mm_a; sb = mm_b; sm = mm_mod;
                        mdl_val   = mont(mm_a, mm_b, mm_mod, mm_len);
                        mdl_cnt   = $urandom_range(6, 2);
                        mdl_phase = mdl_silent ? 3 : 1;
                    end
                    1: begin
                        chk("operands_stable", 64'(mm_a == sa && mm_b == sb && mm_mod == sm), 64'd1);
                        chk("md_start_single_cycle", 64'(md_start), 64'd0);
                        mdl_cnt--;
                        if (mdl_cnt == 0) begin
                            md_end    = 1'b1;
                            mm_out    = mdl_val;
                            mdl_hi    = 2;
                            mdl_phase = 2;
                        end
                    end
                    2: begin
                        chk("operands_stable", 64'(mm_a == sa && mm_b == sb && mm_mod == sm), 64'd1);
                        chk("md_start_while_md_end", 64'(md_start), 64'd0);
                        mdl_hi--;
                        if (mdl_hi == 0) begin
                            md_end    = 1'b0;
                            mm_out    = mdl_val ^ 32'hDEADBEEF;
                            mdl_phase = 0;
                        end
                    end
                    default: if (!mdl_silent) mdl_phase = 0;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    string            cur_name = "none";
    logic [7:0]       exp_len = '0;
    logic             exp_err = 1'b0;
    logic [WIDTH-1:0] exp_result = '0;
    int               exp_pulses = 0;
    int               done_cnt = 0;
    logic [WIDTH-1:0] last_result = '0;
    logic             prev_done = 1'b0;

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            chk("reset_status", 64'({busy, done, err, md_start}), 64'd0);
            chk("reset_result", 64'(result), 64'd0);
            chk("reset_mm_len", 64'(mm_len), 64'd0);
            chk("reset_operands", 64'(|{mm_a, mm_b, mm_mod}), 64'd0);
            last_result = '0;
            prev_done   = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                $display("txn %s len=%0d result=%0h err=%0b md_start_pulses=%0d",
                         cur_name, exp_len, result, err, md_pulses);
                chk({cur_name, "_result"}, 64'(result), 64'(exp_result));
                chk({cur_name, "_err"}, 64'(err), 64'(exp_err));
                chk({cur_name, "_pulses"}, 64'(md_pulses), 64'(exp_pulses));
                chk({cur_name, "_busy_at_done"}, 64'(busy), 64'd0);
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                last_result = result;
            end else if (!busy) begin
                chk("result_hold", 64'(result), 64'(last_result));
            end
            if (busy) chk("mm_len_while_busy", 64'(mm_len), 64'(exp_len));
            prev_done = done;
        end
    end

    // ---------------- directed driver ----------------
    longint done_cyc = 0;

    task automatic run_op(input string name, input logic [7:0] l, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n,
                          input bit extra, input bit silent, input bit hold2, output int lat);
        bit bad;
        bad = (l == 8'd0) || (int'(l) > WIDTH);
        @(negedge clk);
        cur_name   = name;
        exp_len    = l;
        exp_err    = bad || silent;
        exp_result = exp_err ? '0 : WIDTH'(powmod(64'(b), 64'(e), 64'(n), int'(l)));
        exp_pulses = bad ? 0 : (silent ? 1 : pulses_for(int'(l), e));
        mdl_silent = silent;
        md_pulses  = 0;
        len = l; base = b; exponent = e; modulus = n;
        r2_mod = bad ? '0 : WIDTH'(r2_of(64'(n), int'(l)));
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat >= (hold2 ? 2 : 1)) start = 1'b0;
            if (extra && lat == 3) begin
                start = 1'b1; len = 8'd8; base = 32'd3; exponent = '1; modulus = 32'd251;
            end
        end while (!done && lat < 5000);
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_done_wait actual=no_done required=done", name);
        end
        done_cyc = cyc;
        if (start) begin
            @(negedge clk);
            start = 1'b0;
        end
        mdl_silent = 1'b0;
    endtask

    initial begin
        int lat;
        int snap;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // hand-computed pins on the reference arithmetic
        chk("pin_mont_3_3_n13", 64'(mont(32'd3, 32'd3, 32'd13, 8'd4)), 64'd3);
        chk("pin_mont_2_9_n13", 64'(mont(32'd2, 32'd9, 32'd13, 8'd4)), 64'd6);
        chk("pin_r2_n13_len4", r2_of(64'd13, 4), 64'd9);
        chk("pin_pow_2_5_n13", powmod(64'd2, 64'd5, 64'd13, 4), 64'd6);
        chk("pin_pow_3_5_n251", powmod(64'd3, 64'd5, 64'd251, 8), 64'd243);
        chk("pin_pulses_v1", 64'(pulses_for(4, 32'd5)), 64'd9);
        chk("pin_pulses_v2", 64'(pulses_for(32, 32'h10001)), 64'd37);

        run_op("v1", 8'd4, 32'd2, 32'd5, 32'd13, 1'b0, 1'b0, 1'b0, lat);
        chk("v1_result_literal", 64'(result), 64'd6);
        run_op("v2", 8'd32, 32'h12345678, 32'h00010001, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0, lat);
        run_op("v3_n251", 8'd8, 32'd7, 32'd0, 32'd251, 1'b0, 1'b0, 1'b0, lat);
        chk("v3_n251_literal", 64'(result), 64'd1);
        run_op("v3_n1", 8'd8, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, lat);
        chk("v3_n1_literal", 64'(result), 64'd0);

        run_op("v4_len0", 8'd0, 32'd2, 32'd5, 32'd13, 1'b0, 1'b0, 1'b0, lat);
        chk("v4_len0_latency_le2", 64'(lat <= 2), 64'd1);
        // start held into the FIN cycle must not launch a second operation
        run_op("v4_len33", 8'd33, 32'd2, 32'd5, 32'd13, 1'b0, 1'b0, 1'b1, lat);
        chk("v4_len33_latency_le2", 64'(lat <= 2), 64'd1);
        #1 snap = done_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("start_at_fin_ignored", 64'(done_cnt - snap), 64'd0);
        chk("start_at_fin_not_busy", 64'(busy), 64'd0);

        run_op("v5_timeout", 8'd4, 32'd2, 32'd5, 32'd13, 1'b0, 1'b1, 1'b0, lat);
        chk("v5_timeout_cycles", 64'(done_cyc - first_start_cyc), 64'(TIMEOUT_CYC));

        run_op("v5_extra_start", 8'd4, 32'd2, 32'd5, 32'd13, 1'b1, 1'b0, 1'b0, lat);

        // reset during the squaring phase
        @(negedge clk);
        cur_name = "v5_reset"; exp_len = 8'd4; md_pulses = 0;
        len = 8'd4; base = 32'd2; exponent = 32'd5; modulus = 32'd13; r2_mod = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (md_pulses < 4 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("v5_reached_sqr", 64'(md_pulses >= 4), 64'd1);
        chk("v5_busy_before_reset", 64'(busy), 64'd1);
        snap = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("v5_async_reset_busy", 64'(busy), 64'd0);
        chk("v5_async_reset_md_start", 64'(md_start), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("v5_reset_no_done", 64'(done_cnt - snap), 64'd0);
        chk("v5_reset_idle", 64'(busy), 64'd0);

        run_op("v1_after_reset", 8'd4, 32'd2, 32'd5, 32'd13, 1'b0, 1'b0, 1'b0, lat);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
